// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The unit connects through the slave modport; the producer/consumer side uses master.
interface addsub_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic             ci;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             of;

    modport master (
        output in_valid, op, ci, x, y, out_ready,
        input  in_ready, out_valid, r, co, of
    );

    modport slave (
        input  in_valid, op, ci, x, y, out_ready,
        output in_ready, out_valid, r, co, of
    );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial signed add/subtract: DIGIT bits per cycle, LSB digit first, valid/ready on both sides.
// Optional feature macro ADDSUB_SAT_EN: saturate r on signed overflow (co/of still report raw wrap).
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic            clk,
    input logic            rst,
    addsub_serial_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_param_check
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             co_q;
    logic             of_q;
    logic             accept;
    logic             last;
    logic             ovf;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] result;

    assign bus.in_ready  = !rst && ((state == IDLE) || (state == DONE && bus.out_ready));
    assign bus.out_valid = (state == DONE);
    assign bus.r         = acc;
    assign bus.co        = co_q;
    assign bus.of        = of_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (cnt == LAST);

    // ys already holds ~y for subtraction, so the digit adder only ever adds.
    assign dsum = {1'b0, xs[DIGIT-1:0]} + {1'b0, ys[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

    // On the top digit: same-sign operands giving a different-sign sum == carry-in(MSB) ^ carry-out.
    assign ovf = (xs[DIGIT-1] == ys[DIGIT-1]) && (dsum[DIGIT-1] != xs[DIGIT-1]);

    generate
        if (N == 1) begin : g_single
            assign shifted = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign shifted = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef ADDSUB_SAT_EN
    assign result = !ovf           ? shifted :
                    xs[DIGIT-1]    ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign result = shifted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = BUSY;
                end else if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Accept only happens in IDLE/DONE, so it never collides with a BUSY step.
    always_ff @(posedge clk) begin
        if (rst) begin
            xs    <= '0;
            ys    <= '0;
            acc   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            co_q  <= 1'b0;
            of_q  <= 1'b0;
        end else if (accept) begin
            xs    <= bus.x;
            ys    <= bus.op ? ~bus.y : bus.y;
            carry <= bus.op ? ~bus.ci : bus.ci;
            cnt   <= '0;
        end else if (state == BUSY) begin
            xs    <= xs >> DIGIT;
            ys    <= ys >> DIGIT;
            carry <= dsum[DIGIT];
            cnt   <= cnt + CW'(1);
            if (last) begin
                acc  <= result;
                co_q <= dsum[DIGIT];
                of_q <= ovf;
            end else begin
                acc  <= shifted;
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed corner cases, reset abort, backpressure,
// then randomized traffic; expected results are queued at accept and checked by a monitor.
module tb_addsub_serial;
    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;
    localparam int OPS   = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [WIDTH+1:0] exp_q[$];

    addsub_serial_if #(.WIDTH(WIDTH)) bus();

    addsub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: true signed result from integer arithmetic, then wrap or saturate.
    function automatic logic [WIDTH+1:0] model(input logic o, input logic c,
                                               input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa   = longint'($signed(a));
        longint sb   = longint'($signed(b));
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint maxv = (longint'(1) << (WIDTH - 1)) - 1;
        longint minv = -maxv - 1;
        longint t;
        logic [WIDTH-1:0] rr;
        logic cc;
        logic oo;
        if (!o) begin
            t  = sa + sb + longint'(c);
            cc = (ua + ub + longint'(c)) >= (longint'(1) << WIDTH);
        end else begin
            t  = sa - sb - longint'(c);
            cc = ua >= (ub + longint'(c));
        end
        oo = (t > maxv) || (t < minv);
        rr = t[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
        if (oo) rr = (t > 0) ? maxv[WIDTH-1:0] : minv[WIDTH-1:0];
`endif
        return {rr, cc, oo};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveOp(input logic o, input logic c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.op       = o;
        bus.ci       = c;
        bus.x        = a;
        bus.y        = b;
        bus.in_valid = 1'b1;
    endtask

    // Issue one op, hold it until accepted, optionally verify the exact N-edge latency.
    task automatic applyStimulus(input logic o, input logic c, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input bit checkLat);
        bit ok = 1'b0;
        @(posedge clk); #1;
        driveOp(o, c, a, b);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checkOutput("accept timeout", 64'(0), 64'(1));
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(o, c, a, b));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.x        = WIDTH'($urandom);
        bus.y        = WIDTH'($urandom);
        if (checkLat) begin
            for (int i = 0; i <= N; i++) begin
                @(negedge clk);
                checkOutput("latency out_valid", 64'(bus.out_valid), 64'(i == N));
                if (i < N) @(posedge clk);
            end
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        checkOutput("results outstanding", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(5))
            0:       return {1'b0, {(WIDTH-1){1'b1}}};
            1:       return {1'b1, {(WIDTH-1){1'b0}}};
            2:       return '1;
            3:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic randomPhase();
        int issued  = 0;
        int cycles  = 0;
        bit pending = 1'b0;
        logic o, c;
        logic [WIDTH-1:0] a, b;
        while (issued < OPS && cycles < 60000) begin
            @(posedge clk); #1;
            cycles++;
            bus.out_ready = ($urandom_range(3) != 0);
            if (!pending) begin
                if ($urandom_range(2) != 0) begin
                    o = 1'($urandom_range(1));
                    c = 1'($urandom_range(1));
                    a = pickOperand();
                    b = pickOperand();
                    driveOp(o, c, a, b);
                    pending = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                    bus.x        = WIDTH'($urandom);
                end
            end
            @(negedge clk);
            if (pending && bus.in_ready) begin
                exp_q.push_back(model(o, c, a, b));
                pending = 1'b0;
                issued++;
            end
        end
        checkOutput("random ops issued", 64'(issued), 64'(OPS));
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        waitDrain(100);
    endtask

    // Scoreboard monitor: while a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected out_valid", 64'(1), 64'(0));
            end else begin
                checkOutput("result {r,co,of}", 64'({bus.r, bus.co, bus.of}), 64'(exp_q[0]));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int stale;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.ci        = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready during reset", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset {r,co,of}", 64'({bus.r, bus.co, bus.of}), 64'(0));
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'(1));

        $display("[TB] directed corner cases");
        applyStimulus(1'b0, 1'b0, 16'h7FFF, 16'h0001, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0001, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h8000, 16'h0001, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h8000, 16'h7FFF, 1'b1);
        waitDrain(20);

        $display("[TB] reset in the middle of BUSY");
        applyStimulus(1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready with rst high", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("post-reset {r,co,of}", 64'({bus.r, bus.co, bus.of}), 64'(0));
        checkOutput("post-reset in_ready", 64'(bus.in_ready), 64'(1));
        stale = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        checkOutput("stale out_valid after reset", 64'(stale), 64'(0));

        $display("[TB] backpressure and back-to-back accept");
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h7FFF, 16'h7FFF, 1'b1);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall in_ready", 64'(bus.in_ready), 64'(0));
            checkOutput("stall out_valid", 64'(bus.out_valid), 64'(1));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        driveOp(1'b1, 1'b1, 16'h0005, 16'h0009);
        @(negedge clk);
        checkOutput("back-to-back in_ready", 64'(bus.in_ready), 64'(1));
        if (bus.in_ready) exp_q.push_back(model(1'b1, 1'b1, 16'h0005, 16'h0009));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy after back-to-back", 64'(bus.out_valid), 64'(0));
        waitDrain(20);

        $display("[TB] randomized traffic, %0d ops", OPS);
        randomPhase();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
